// File: rtl/sh7604_bus_arb.sv
// Bus arbiter letting a slave SH7604 and an external DMA master borrow the bus
// from the master CPU via its BRLS_N/BGR_N release handshake.
module sh7604_bus_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic       M_BGR_N,
    output logic       M_BRLS_N,
    input  logic       S_BREQ_N,
    output logic       S_BACK_N,
    input  logic       E_REQ,
    output logic       E_GNT,
    output logic [1:0] BUS_SEL,
    output logic       ERR,
    input  logic       ERR_CLR
);

    typedef enum logic [2:0] {
        ST_MASTER,
        ST_REL_WAIT,
        ST_SLAVE,
        ST_EXT,
        ST_HANDOFF,
        ST_RETURN
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       last, last_nxt;
    logic       timeout;
    logic       s_pend, e_pend;

    logic       brls_n_d, back_n_d, gnt_d, err_d;
    logic [1:0] sel_d;

    assign s_pend = ~S_BREQ_N;
    assign e_pend = E_REQ;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_MASTER;
            wait_cnt <= '0;
            last     <= 1'b0;
            M_BRLS_N <= 1'b1;
            S_BACK_N <= 1'b1;
            E_GNT    <= 1'b0;
            BUS_SEL  <= 2'd0;
            ERR      <= 1'b0;
        end else if (CE_R) begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            last     <= last_nxt;
            M_BRLS_N <= brls_n_d;
            S_BACK_N <= back_n_d;
            E_GNT    <= gnt_d;
            BUS_SEL  <= sel_d;
            ERR      <= err_d;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        last_nxt     = last;
        timeout      = 1'b0;
        case (state)
            ST_MASTER: begin
                if (s_pend || e_pend) begin
                    state_nxt    = ST_REL_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_REL_WAIT: begin
                // A grant from the master takes priority over a coincident timeout
                if (!M_BGR_N) begin
                    if (s_pend && e_pend)
                        state_nxt = last ? ST_SLAVE : ST_EXT;
                    else if (s_pend)
                        state_nxt = ST_SLAVE;
                    else if (e_pend)
                        state_nxt = ST_EXT;
                    else
                        state_nxt = ST_RETURN;
                end else if (wait_cnt + 8'd1 >= TIMEOUT_C) begin
                    timeout      = 1'b1;
                    state_nxt    = ST_MASTER;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ST_SLAVE: begin
                if (!s_pend) begin
                    last_nxt  = 1'b1;
                    state_nxt = ST_HANDOFF;
                end
            end
            ST_EXT: begin
                if (!e_pend) begin
                    last_nxt  = 1'b0;
                    state_nxt = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                // LAST names the requester that just left; the other one goes first
                if (last ? e_pend : s_pend)
                    state_nxt = last ? ST_EXT : ST_SLAVE;
                else if (s_pend)
                    state_nxt = ST_SLAVE;
                else if (e_pend)
                    state_nxt = ST_EXT;
                else
                    state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                if (M_BGR_N)
                    state_nxt = ST_MASTER;
            end
            default: state_nxt = ST_MASTER;
        endcase
    end

    always_comb begin
        brls_n_d = 1'b0;
        back_n_d = 1'b1;
        gnt_d    = 1'b0;
        sel_d    = 2'd3;
        case (state_nxt)
            ST_MASTER: begin
                brls_n_d = 1'b1;
                sel_d    = 2'd0;
            end
            ST_REL_WAIT: sel_d = 2'd0;
            ST_SLAVE: begin
                back_n_d = 1'b0;
                sel_d    = 2'd1;
            end
            ST_EXT: begin
                gnt_d = 1'b1;
                sel_d = 2'd2;
            end
            ST_HANDOFF: sel_d = 2'd3;
            ST_RETURN:  brls_n_d = 1'b1;
            default: begin
                brls_n_d = 1'b1;
                sel_d    = 2'd0;
            end
        endcase
        err_d = timeout ? 1'b1 : (ERR_CLR ? 1'b0 : ERR);
    end

endmodule

// File: doc/sh7604_bus_arb.md
SH7604_BUS_ARB -- requirements
Module: sh7604_bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of CE_R ticks spent waiting for the master to release the bus (range 1..255).
REQ-002 CLK  in  1  system clock.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 CE_R  in  1  clock enable; all state, counter and output updates occur only on CLK edges with CE_R=1.
REQ-005 M_BGR_N  in  1  master CPU bus-grant output; low means the master has floated its bus.
REQ-006 M_BRLS_N  out  1  drives the master BRLS_N input; low requests bus release.
REQ-007 S_BREQ_N  in  1  slave CPU bus request; low means the slave wants the bus.
REQ-008 S_BACK_N  out  1  slave bus acknowledge; low means the slave owns the bus.
REQ-009 E_REQ  in  1  external bus-master (DMA) request, active-high.
REQ-010 E_GNT  out  1  external bus-master grant, active-high.
REQ-011 BUS_SEL  out  2  pin-mux select: 0 = master, 1 = slave, 2 = external, 3 = none (bus floating).
REQ-012 ERR  out  1  sticky release-timeout flag.
REQ-013 ERR_CLR  in  1  clears ERR.

Function
REQ-014 FSM states: MASTER, REL_WAIT, SLAVE, EXT, HANDOFF, RETURN.
REQ-015 All outputs SHALL be registered.
REQ-016 Outputs per state:
- MASTER: M_BRLS_N=1, BUS_SEL=0.
- REL_WAIT: M_BRLS_N=0, BUS_SEL=0.
- SLAVE: M_BRLS_N=0, S_BACK_N=0, BUS_SEL=1.
- EXT: M_BRLS_N=0, E_GNT=1, BUS_SEL=2.
- HANDOFF: M_BRLS_N=0, BUS_SEL=3, no grant active.
- RETURN: M_BRLS_N=1, BUS_SEL=3.
REQ-017 MASTER: on a tick where S_BREQ_N=0 or E_REQ=1, go to REL_WAIT and clear the wait counter.
REQ-018 REL_WAIT: on a tick where M_BGR_N=0, go to the granted state.
- If both requests are pending: grant EXT when the LAST bit is 0, otherwise SLAVE.
- If only one request is pending: grant that requester.
- If no request is pending: go to RETURN.
REQ-019 REL_WAIT: the counter increments on each tick where M_BGR_N=1. When it reaches TIMEOUT, go to MASTER and set ERR=1; no grant is issued.
REQ-020 SLAVE: on a tick where S_BREQ_N=1, set LAST=1 and go to HANDOFF.
REQ-021 EXT: on a tick where E_REQ=0, set LAST=0 and go to HANDOFF.
REQ-022 HANDOFF lasts exactly one tick; the next state is evaluated in that tick.
- If the other requester is pending: grant it (SLAVE or EXT) without returning the bus to the master.
- Else if the same requester is pending again: grant it.
- Else: go to RETURN.
REQ-023 RETURN: on a tick where M_BGR_N=1, go to MASTER.
REQ-024 A grant SHALL never be issued in the same tick another grant is removed; at least one tick with BUS_SEL=3 separates two owners.
REQ-025 S_BACK_N=0 and E_GNT=1 SHALL never occur together.
REQ-026 A grant is held regardless of requests from other requesters; there is no preemption.
REQ-027 Requests withdrawn during REL_WAIT are not latched; pending status is the live input value.
REQ-028 ERR clears on a tick where ERR_CLR=1. If ERR_CLR=1 and a timeout occur in the same tick, the timeout wins and ERR=1.
REQ-029 Latency from a request in MASTER to its grant is 2 ticks plus the master release time.

Reset
REQ-030 While RST_N=0, regardless of CE_R:
- state = MASTER, counter = 0, LAST = 0;
- M_BRLS_N=1, S_BACK_N=1, E_GNT=0, BUS_SEL=0, ERR=0.
REQ-031 Reset asserted mid-tenure SHALL drop any grant immediately, asynchronously.

Verification
REQ-032 Slave-only request:
- Stimulus: S_BREQ_N=0; M_BGR_N falls 3 ticks after M_BRLS_N falls; slave later releases.
- Response: M_BRLS_N=0 one tick after the request; S_BACK_N=0 and BUS_SEL=1 one tick after M_BGR_N=0.
- After S_BREQ_N=1: BUS_SEL=3 for one tick, then RETURN, then MASTER with BUS_SEL=0 once M_BGR_N=1.
REQ-033 Simultaneous requests:
- Stimulus: S_BREQ_N=0 and E_REQ=1 on the same tick with LAST=0.
- Response: EXT granted first. On E_REQ=0, one HANDOFF tick (BUS_SEL=3), then S_BACK_N=0 while M_BRLS_N stays 0.
REQ-034 Alternation:
- Stimulus: both requesters hold their requests, and each drops it for one tick after 4 ticks of ownership.
- Response: grants alternate SLAVE, EXT, SLAVE, ...; E_GNT and S_BACK_N never overlap.
REQ-035 Timeout:
- Stimulus: TIMEOUT=4, E_REQ=1, M_BGR_N held at 1.
- Response: after 4 wait ticks, state = MASTER, M_BRLS_N=1, ERR=1, E_GNT=0.
- Then ERR_CLR=1 for one tick gives ERR=0.
REQ-036 Reset mid-operation:
- Stimulus: RST_N=0 during EXT ownership.
- Response: E_GNT=0, M_BRLS_N=1 and BUS_SEL=0 without waiting for CLK; after release, no grant until a new request.
REQ-037 CE_R gating:
- Stimulus: CE_R=0 for 10 cycles while requests toggle.
- Response: no state, counter or output change during those cycles.
